imem_load_controller: RTL and testbench
=======================================

Name: imem_load_controller

Overview:
- Sequences the single instruction-memory port between two users: program loading from a byte stream (debug/UART side) and CPU instruction fetch.
- Load phase: assembles 32-bit words from bytes, writes them to byte addresses 0, 4, 8, …, and stops on the halt word.
- Run phase: hands the address port to the CPU PC and enables the CPU until the CPU reports halt.

Parameters:
- NBITS, 32, instruction/address width.
- CELDAS, 60, memory cells; valid word addresses 0..CELDAS-4, step 4.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker; written to memory like any other word.
- TIMEOUT_CYCLES, 1000, byte-gap limit (optional feature only).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_load_start  in  1  one-cycle pulse: begin a new program load.
- i_rx_data  in  8  byte to load.
- i_rx_valid  in  1  i_rx_data is valid.
- o_rx_ready  out  1  controller accepts a byte this cycle.
- i_run  in  1  pulse: start CPU execution after a successful load.
- i_cpu_pc  in  NBITS  CPU fetch address.
- i_cpu_halt  in  1  CPU has executed the halt instruction.
- o_mem_addr  out  NBITS  memory address.
- o_mem_we  out  1  memory write strobe.
- o_mem_wdata  out  NBITS  memory write data.
- o_cpu_enable  out  1  CPU clock enable.
- o_load_done  out  1  program loaded and awaiting i_run, or execution finished.
- o_error  out  1  load overflow (or timeout).
- o_word_count  out  16  words written in the current load.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - State IDLE.
  - Address, byte and word counters, and assembly register cleared to 0.
  - All outputs 0.
  - Reset asserted mid-load or mid-run aborts immediately; memory contents are not touched.
- Handshake: a byte transfers on a rising edge with i_rx_valid=1 and o_rx_ready=1. o_rx_ready=1 only in state LOAD. Bytes presented in any other state are not consumed.
- Byte order: the first byte of each word goes to bits [31:24], the fourth byte to bits [7:0].
- States:
  - IDLE: on i_load_start → LOAD; address=0, word count=0.
  - LOAD: accept bytes; the 4th accepted byte moves to WRITE on the next cycle.
  - WRITE (exactly 1 cycle): o_mem_we=1, o_mem_addr=load address, o_mem_wdata=assembled word; load address +=4; o_word_count +=1. Next state, in priority order:
    - word==HALT_WORD → READY.
    - new address > CELDAS-4 → ERROR.
    - otherwise → LOAD.
  - READY: o_load_done=1; i_run → RUN; i_load_start → LOAD (reload from address 0).
  - RUN: o_cpu_enable=1; o_mem_addr=i_cpu_pc (combinational passthrough); o_mem_we=0. i_cpu_halt → DONE on the next edge; o_cpu_enable is 0 from that edge on. i_load_start and i_run are ignored.
  - DONE: o_load_done=1; i_load_start → LOAD with counters cleared; i_run → RUN (re-execute; CPU PC reset is the CPU's responsibility).
  - ERROR: o_error=1; only i_load_start (→ LOAD, clears o_error and counters) or reset leaves this state.
- o_mem_addr outside RUN = load address register. o_mem_wdata outside WRITE = assembly register; its value is don't-care for memory.
- Latency: 4th byte edge → o_mem_we high for the following cycle. The halt word's WRITE → o_load_done on the next cycle.
- Simultaneous i_load_start and i_run in READY/DONE: i_load_start wins.
- o_word_count holds its value through READY, RUN and DONE.

Optional Feature:
- Macro IMEM_LOAD_TIMEOUT_EN.
- Defined:
  - In LOAD with 1–3 bytes of the current word received, a gap counter increments each cycle without a byte transfer.
  - Reaching TIMEOUT_CYCLES → ERROR; the partial word is discarded and never written.
  - The counter clears on each accepted byte.
  - With 0 bytes pending, there is no timeout.
- Not defined: no gap counter; LOAD waits indefinitely.

Test Plan:
- Reset during LOAD after 2 bytes → all outputs 0 immediately, state IDLE; a subsequent i_load_start restarts at address 0.
- Load 3 words (bytes 20 00 00 00, 00 01 10 21, then FF FF FF FF) → writes 32'h20000000@0, 32'h00011021@4, 32'hFFFFFFFF@8; o_word_count=3; o_load_done=1.
- Stream 15 non-halt words with CELDAS=60 → writes at 0..56, then o_error=1 and o_rx_ready=0. i_load_start clears o_error and resumes at address 0.
- After a load, pulse i_run; drive i_cpu_pc=0,4,8 → o_mem_addr follows with o_cpu_enable=1. i_cpu_halt=1 → o_cpu_enable=0 on the next edge, o_load_done=1.
- i_rx_valid=1 held in READY and RUN → o_rx_ready=0, no writes. i_load_start during RUN → ignored.
- IMEM_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=10: send 2 bytes, then idle 10 cycles → o_error=1, no write. Repeat with 0 bytes sent → no error.

Source files
------------

// File: rtl/imem_load_controller.sv
// imem_load_controller
// Arbitrates the single instruction-memory port between a byte-stream program
// loader and CPU instruction fetch. Bytes are packed big-endian into 32-bit
// words and written to byte addresses 0, 4, 8, ... until the halt word is seen.
// After a successful load, i_run hands the address port to the CPU PC until the
// CPU reports halt.
// Optional build macro IMEM_LOAD_TIMEOUT_EN: aborts a load with an error when
// a partially received word sees TIMEOUT_CYCLES consecutive cycles without a byte.
module imem_load_controller #(
  parameter int               NBITS     = 32,
  parameter int               CELDAS    = 60,
  parameter logic [NBITS-1:0] HALT_WORD = {NBITS{1'b1}}
`ifdef IMEM_LOAD_TIMEOUT_EN
  , parameter int             TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load_start,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  input  logic             i_run,
  input  logic [NBITS-1:0] i_cpu_pc,
  input  logic             i_cpu_halt,
  output logic [NBITS-1:0] o_mem_addr,
  output logic             o_mem_we,
  output logic [NBITS-1:0] o_mem_wdata,
  output logic             o_cpu_enable,
  output logic             o_load_done,
  output logic             o_error,
  output logic [15:0]      o_word_count
);

  // Highest byte address that may still receive a word.
  localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_READY,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_reg, state_next;
  logic [NBITS-1:0] addr_reg, addr_next;
  logic [NBITS-1:0] asm_reg, asm_next;
  logic [1:0]       byte_cnt_reg, byte_cnt_next;
  logic [15:0]      word_cnt_reg, word_cnt_next;
  logic             restart;

  logic rx_ready_reg;
  logic mem_we_reg;
  logic cpu_enable_reg;
  logic load_done_reg;
  logic error_reg;

`ifdef IMEM_LOAD_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
`endif

  // Next-state and datapath decisions for the load/run sequencer.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    asm_next      = asm_reg;
    byte_cnt_next = byte_cnt_reg;
    word_cnt_next = word_cnt_reg;
    restart       = 1'b0;
`ifdef IMEM_LOAD_TIMEOUT_EN
    gap_cnt_next  = gap_cnt_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        if (i_load_start) restart = 1'b1;
      end

      S_LOAD: begin
        // o_rx_ready is high in this state, so a valid byte always transfers.
        if (i_rx_valid) begin
          asm_next      = {asm_reg[NBITS-9:0], i_rx_data};
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) state_next = S_WRITE;
`ifdef IMEM_LOAD_TIMEOUT_EN
          gap_cnt_next = '0;
        end else if (byte_cnt_reg != 2'd0) begin
          // Only a partially assembled word can time out; it is dropped.
          if (gap_cnt_reg == GAP_W'(TIMEOUT_CYCLES - 1)) begin
            state_next    = S_ERROR;
            byte_cnt_next = 2'd0;
            gap_cnt_next  = '0;
          end else begin
            gap_cnt_next = gap_cnt_reg + GAP_W'(1);
          end
`endif
        end
      end

      S_WRITE: begin
        addr_next     = addr_reg + NBITS'(4);
        word_cnt_next = word_cnt_reg + 16'd1;
        if (asm_reg == HALT_WORD)     state_next = S_READY;
        else if (addr_next > LAST_ADDR) state_next = S_ERROR;
        else                          state_next = S_LOAD;
      end

      S_READY, S_DONE: begin
        // A new load takes priority over (re)starting execution.
        if (i_load_start)  restart    = 1'b1;
        else if (i_run)    state_next = S_RUN;
      end

      S_RUN: begin
        if (i_cpu_halt) state_next = S_DONE;
      end

      S_ERROR: begin
        if (i_load_start) restart = 1'b1;
      end

      default: state_next = S_IDLE;
    endcase

    if (restart) begin
      state_next    = S_LOAD;
      addr_next     = '0;
      byte_cnt_next = 2'd0;
      word_cnt_next = 16'd0;
`ifdef IMEM_LOAD_TIMEOUT_EN
      gap_cnt_next  = '0;
`endif
    end
  end

  // State, counters and registered status flags decoded from the next state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg      <= S_IDLE;
      addr_reg       <= '0;
      asm_reg        <= '0;
      byte_cnt_reg   <= 2'd0;
      word_cnt_reg   <= 16'd0;
      rx_ready_reg   <= 1'b0;
      mem_we_reg     <= 1'b0;
      cpu_enable_reg <= 1'b0;
      load_done_reg  <= 1'b0;
      error_reg      <= 1'b0;
`ifdef IMEM_LOAD_TIMEOUT_EN
      gap_cnt_reg    <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      asm_reg        <= asm_next;
      byte_cnt_reg   <= byte_cnt_next;
      word_cnt_reg   <= word_cnt_next;
      rx_ready_reg   <= (state_next == S_LOAD);
      mem_we_reg     <= (state_next == S_WRITE);
      cpu_enable_reg <= (state_next == S_RUN);
      load_done_reg  <= (state_next == S_READY) || (state_next == S_DONE);
      error_reg      <= (state_next == S_ERROR);
`ifdef IMEM_LOAD_TIMEOUT_EN
      gap_cnt_reg    <= gap_cnt_next;
`endif
    end
  end

  assign o_rx_ready   = rx_ready_reg;
  assign o_mem_we     = mem_we_reg;
  assign o_cpu_enable = cpu_enable_reg;
  assign o_load_done  = load_done_reg;
  assign o_error      = error_reg;
  assign o_word_count = word_cnt_reg;
  assign o_mem_wdata  = asm_reg;
  // The CPU owns the address port only while it is running.
  assign o_mem_addr   = cpu_enable_reg ? i_cpu_pc : addr_reg;

endmodule

// File: tb/tb_imem_load_controller.sv
// Self-checking bench for imem_load_controller: a phase-level reference model
// predicts every output each cycle; directed and randomized loads/runs.
module tb_imem_load_controller;

  localparam int CELDAS = 60;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;
`ifdef IMEM_LOAD_TIMEOUT_EN
  localparam int TO = 10;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_load_start = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_ready;
  logic        i_run = 1'b0;
  logic [31:0] i_cpu_pc = 32'h0;
  logic        i_cpu_halt = 1'b0;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [31:0] o_mem_wdata;
  logic        o_cpu_enable;
  logic        o_load_done;
  logic        o_error;
  logic [15:0] o_word_count;

  imem_load_controller #(
    .NBITS(32),
    .CELDAS(CELDAS)
`ifdef IMEM_LOAD_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_load_start(i_load_start),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .i_run(i_run), .i_cpu_pc(i_cpu_pc), .i_cpu_halt(i_cpu_halt),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .o_cpu_enable(o_cpu_enable), .o_load_done(o_load_done), .o_error(o_error),
    .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  // READY and DONE behave identically, so the model keeps one AWAIT phase.
  typedef enum int {P_IDLE, P_LOAD, P_WRITE, P_AWAIT, P_RUN, P_ERR} phase_t;
  phase_t      ph;
  int unsigned m_addr, m_count, m_n, m_gap;
  logic [31:0] m_word;

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ph <= P_IDLE; m_addr <= 0; m_count <= 0; m_n <= 0; m_gap <= 0; m_word <= 0;
    end else begin
      case (ph)
        P_IDLE:
          if (i_load_start) begin
            ph <= P_LOAD; m_addr <= 0; m_count <= 0; m_n <= 0; m_gap <= 0;
          end
        P_LOAD:
          if (i_rx_valid) begin
            m_word <= ((m_n == 0) ? 32'd0 : m_word) | (32'(i_rx_data) << (8 * (3 - m_n)));
            m_n    <= (m_n + 1) % 4;
            m_gap  <= 0;
            if (m_n == 3) ph <= P_WRITE;
          end
`ifdef IMEM_LOAD_TIMEOUT_EN
          else if (m_n != 0) begin
            if (m_gap + 1 >= TO) begin
              ph <= P_ERR; m_n <= 0; m_gap <= 0;
            end else begin
              m_gap <= m_gap + 1;
            end
          end
`endif
        P_WRITE: begin
          m_addr  <= m_addr + 4;
          m_count <= m_count + 1;
          if (m_word == HALT)                 ph <= P_AWAIT;
          else if (m_count + 1 >= CELDAS / 4) ph <= P_ERR;
          else                                ph <= P_LOAD;
        end
        P_AWAIT:
          if (i_load_start) begin
            ph <= P_LOAD; m_addr <= 0; m_count <= 0; m_n <= 0; m_gap <= 0;
          end else if (i_run) begin
            ph <= P_RUN;
          end
        P_RUN:
          if (i_cpu_halt) ph <= P_AWAIT;
        P_ERR:
          if (i_load_start) begin
            ph <= P_LOAD; m_addr <= 0; m_count <= 0; m_n <= 0; m_gap <= 0;
          end
        default: ;
      endcase
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t wlog[$];

  function automatic logic [31:0] b2w(input logic b);
    return {31'b0, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    if (i_reset === 1'b1) begin
      check("rx_ready",   b2w(o_rx_ready),   b2w(ph == P_LOAD));
      check("mem_we",     b2w(o_mem_we),     b2w(ph == P_WRITE));
      check("cpu_enable", b2w(o_cpu_enable), b2w(ph == P_RUN));
      check("load_done",  b2w(o_load_done),  b2w(ph == P_AWAIT));
      check("error",      b2w(o_error),      b2w(ph == P_ERR));
      check("word_count", 32'(o_word_count), m_count);
      check("mem_addr",   o_mem_addr,        (ph == P_RUN) ? i_cpu_pc : m_addr);
      if (ph == P_WRITE) check("mem_wdata", o_mem_wdata, m_word);
      if (o_mem_we === 1'b1) begin
        wlog.push_back('{o_mem_addr, o_mem_wdata});
        $display("WRITE addr=%0d data=%h count=%0d", o_mem_addr, o_mem_wdata, o_word_count);
      end
    end
  endtask

  // One cycle: compare on the falling edge, then drive 2 time units past rising.
  task automatic tick();
    @(negedge i_clk);
    compare_all();
    @(posedge i_clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    for (int k = 0; k < 50 && !ok; k++) begin
      ok = o_rx_ready;
      tick();
    end
    i_rx_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rx_accept actual=not_ready_50_cycles required=byte_accepted");
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[8*i +: 8]);
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
    end
  endtask

  task automatic pulse_load();
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
  endtask

  task automatic wait_for_end();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (o_load_done || o_error) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL load_end actual=no_done_or_error required=done_or_error");
    end
  endtask

  task automatic run_and_halt(input int ncyc, input bit junk);
    i_run = 1'b1;
    tick();
    i_run = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      i_cpu_pc     = 32'($urandom_range(0, CELDAS / 4 - 1) * 4);
      i_rx_valid   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      i_load_start = junk ? ($urandom_range(0, 3) == 0) : 1'b0;
      tick();
    end
    i_load_start = 1'b0;
    i_rx_valid   = 1'b0;
    i_cpu_halt   = 1'b1;
    tick();
    i_cpu_halt   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    int n;
    bit ovf;

    // Reset state
    repeat (3) tick();
    check("reset_flags", {11'b0, o_rx_ready, o_mem_we, o_cpu_enable, o_load_done, o_error, o_word_count}, 32'h0);
    check("reset_addr", o_mem_addr, 32'h0);
    check("reset_wdata", o_mem_wdata, 32'h0);
    i_reset = 1'b1;
    tick();

    // Reset asserted in the middle of a load
    pulse_load();
    send_byte(8'hA5);
    send_byte(8'h5A);
    #1 i_reset = 1'b0;
    #1;
    check("midload_reset_flags", {11'b0, o_rx_ready, o_mem_we, o_cpu_enable, o_load_done, o_error, o_word_count}, 32'h0);
    check("midload_reset_addr", o_mem_addr, 32'h0);
    check("midload_reset_wdata", o_mem_wdata, 32'h0);
    tick();
    i_reset = 1'b1;
    tick();

    // Three-word program
    wlog.delete();
    pulse_load();
    send_word(32'h20000000, 0);
    send_word(32'h00011021, 2);
    send_word(HALT, 1);
    wait_for_end();
    check("prog3_nwrites", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("prog3_a0", wlog[0].a, 32'd0); check("prog3_d0", wlog[0].d, 32'h20000000);
      check("prog3_a1", wlog[1].a, 32'd4); check("prog3_d1", wlog[1].d, 32'h00011021);
      check("prog3_a2", wlog[2].a, 32'd8); check("prog3_d2", wlog[2].d, 32'hFFFFFFFF);
    end
    check("prog3_count", 32'(o_word_count), 32'd3);
    check("prog3_done", b2w(o_load_done), 32'd1);

    // Bytes offered while READY are not consumed
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h77;
    repeat (4) tick();
    check("ready_no_accept", b2w(o_rx_ready), 32'd0);

    // Run: CPU PC drives the address port; load_start ignored
    i_rx_valid = 1'b0;
    i_run = 1'b1;
    tick();
    i_run = 1'b0;
    for (int p = 0; p < 3; p++) begin
      i_cpu_pc   = 32'(p * 4);
      i_rx_valid = 1'b1;
      #1;
      check("run_addr", o_mem_addr, 32'(p * 4));
      check("run_enable", b2w(o_cpu_enable), 32'd1);
      tick();
    end
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    i_rx_valid   = 1'b0;
    check("run_ignores_load", b2w(o_cpu_enable), 32'd1);
    check("run_no_writes", wlog.size(), 3);
    i_cpu_halt = 1'b1;
    tick();
    i_cpu_halt = 1'b0;
    check("halt_enable_off", b2w(o_cpu_enable), 32'd0);
    check("halt_done", b2w(o_load_done), 32'd1);
    check("halt_count_held", 32'(o_word_count), 32'd3);

    // load_start and run together in DONE: load wins
    i_load_start = 1'b1;
    i_run = 1'b1;
    tick();
    i_load_start = 1'b0;
    i_run = 1'b0;
    check("both_load_wins", b2w(o_rx_ready), 32'd1);
    check("both_no_run", b2w(o_cpu_enable), 32'd0);
    send_word(HALT, 0);
    wait_for_end();

    // Overflow: 15 non-halt words fill addresses 0..56
    wlog.delete();
    pulse_load();
    for (int i = 0; i < CELDAS / 4; i++) begin
      w = $urandom;
      if (w == HALT) w = 32'h0;
      send_word(w, 0);
    end
    wait_for_end();
    check("ovf_error", b2w(o_error), 32'd1);
    check("ovf_rx_ready", b2w(o_rx_ready), 32'd0);
    check("ovf_nwrites", wlog.size(), 15);
    if (wlog.size() == 15) check("ovf_last_addr", wlog[14].a, 32'd56);
    i_rx_valid = 1'b1;
    repeat (3) tick();
    i_rx_valid = 1'b0;
    check("err_no_writes", wlog.size(), 15);
    wlog.delete();
    pulse_load();
    check("reload_err_clear", b2w(o_error), 32'd0);
    send_word(HALT, 0);
    wait_for_end();
    check("reload_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) check("reload_addr0", wlog[0].a, 32'd0);

`ifdef IMEM_LOAD_TIMEOUT_EN
    // Timeout with a partial word pending
    wlog.delete();
    pulse_load();
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (TO - 1) tick();
    check("to_not_yet", b2w(o_error), 32'd0);
    tick();
    check("to_error", b2w(o_error), 32'd1);
    check("to_no_write", wlog.size(), 0);
    // No timeout when no bytes are pending
    pulse_load();
    repeat (3 * TO) tick();
    check("to_idle_no_error", b2w(o_error), 32'd0);
    check("to_idle_ready", b2w(o_rx_ready), 32'd1);
    send_word(HALT, 0);
    wait_for_end();
`endif

    // Randomized programs and runs
    for (int it = 0; it < 25; it++) begin
      pulse_load();
      n   = $urandom_range(1, CELDAS / 4);
      ovf = (n == CELDAS / 4) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < n; i++) begin
        if (i == n - 1 && !ovf) begin
          w = HALT;
        end else begin
          w = $urandom;
          if (w == HALT) w = 32'h1;
        end
        send_word(w, 2);
      end
      wait_for_end();
      if (o_load_done) run_and_halt($urandom_range(1, 8), 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
